// File: rtl/dnn_argmax_scan.sv
// dnn_argmax_scan
//   Classification stage behind the sigmoid inference engine. A rising edge on
//   eng_done starts a scan. The scan walks out_idx from 0 to NUM_CLASSES-1 and
//   samples the signed score that the engine returns for each index. It then
//   holds the winning class, its score and the margin over the runner-up until
//   the next inference or a clear.
//
//   Ports
//     clk          system clock, rising edge
//     rst          asynchronous reset, active low
//     clear        synchronous clear; aborts a scan and drops result_valid
//     eng_done     engine done level; a rising edge starts a scan
//     out_idx      score select driven to the engine output mux
//     score_in     signed score for out_idx, valid in the same cycle
//     busy         high while scanning
//     result_valid high while class_id / max_score / margin are valid
//     class_id     index of the winning class (lowest index wins ties)
//     max_score    signed winning score
//     margin       unsigned best minus second-best, DATA_WIDTH+1 bits
module dnn_argmax_scan #(
  parameter int DATA_WIDTH  = 2,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         eng_done,
  output logic [IDX_WIDTH-1:0]         out_idx,
  input  logic signed [DATA_WIDTH-1:0] score_in,
  output logic                         busy,
  output logic                         result_valid,
  output logic [IDX_WIDTH-1:0]         class_id,
  output logic signed [DATA_WIDTH-1:0] max_score,
  output logic [DATA_WIDTH:0]          margin
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_WIDTH-1:0]         LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                       state, state_nxt;
  logic                         done_q;
  logic                         start_pulse;
  logic [IDX_WIDTH-1:0]         idx;
  logic signed [DATA_WIDTH-1:0] best, best_nxt;
  logic signed [DATA_WIDTH-1:0] second, second_nxt;
  logic [IDX_WIDTH-1:0]         best_idx, best_idx_nxt;
  logic                         scan_done;

  // best >= second always holds, so the sign-extended difference is never
  // negative and fits in DATA_WIDTH+1 unsigned bits.
  function automatic logic [DATA_WIDTH:0] calc_margin(
    input logic signed [DATA_WIDTH-1:0] hi,
    input logic signed [DATA_WIDTH-1:0] lo
  );
    logic signed [DATA_WIDTH:0] diff;
    diff = {hi[DATA_WIDTH-1], hi} - {lo[DATA_WIDTH-1], lo};
    return $unsigned(diff);
  endfunction

  assign start_pulse = eng_done & ~done_q;

  // Running best / second-best including the score sampled this cycle.
  always_comb begin
    best_nxt     = best;
    second_nxt   = second;
    best_idx_nxt = best_idx;
    if (idx == '0) begin
      best_nxt     = score_in;
      second_nxt   = SCORE_MIN;
      best_idx_nxt = '0;
    end else if (score_in > best) begin
      second_nxt   = best;
      best_nxt     = score_in;
      best_idx_nxt = idx;
    end else if (score_in > second) begin
      // Also taken on a tie with best: the lower index is kept and margin is 0.
      second_nxt   = score_in;
    end
  end

  // An eng_done fall during SCAN means the engine restarted: abort the scan.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!clear && start_pulse) state_nxt = SCAN;
      end
      SCAN: begin
        if (clear || !eng_done)   state_nxt = IDLE;
        else if (idx == LAST_IDX) state_nxt = HOLD;
      end
      HOLD: begin
        if (clear)            state_nxt = IDLE;
        else if (start_pulse) state_nxt = SCAN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign scan_done = (state == SCAN) && (state_nxt == HOLD);

  // Control and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      idx       <= '0;
      class_id  <= '0;
      max_score <= '0;
      margin    <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= eng_done;
      idx    <= (state == SCAN && state_nxt == SCAN) ? idx + 1'b1 : '0;
      if (scan_done) begin
        class_id  <= best_idx_nxt;
        max_score <= best_nxt;
        margin    <= calc_margin(best_nxt, second_nxt);
      end
    end
  end

  // Scan accumulators; these are reseeded at idx 0 and so need no reset.
  always_ff @(posedge clk) begin
    if (state == SCAN) begin
      best     <= best_nxt;
      second   <= second_nxt;
      best_idx <= best_idx_nxt;
    end
  end

  assign out_idx      = (state == SCAN) ? idx : '0;
  assign busy         = (state == SCAN);
  assign result_valid = (state == HOLD);

endmodule

// File: tb/tb_dnn_argmax_scan.sv
module tb_dnn_argmax_scan;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              eng_done;
  logic [3:0]        out_idx;
  logic signed [1:0] score_in;
  logic              busy;
  logic              result_valid;
  logic [3:0]        class_id;
  logic signed [1:0] max_score;
  logic [2:0]        margin;

  logic signed [1:0] scores [16];
  int                vec [10];
  int                vecs;
  int                errs;

  dnn_argmax_scan #(.DATA_WIDTH(2), .NUM_CLASSES(10), .IDX_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .eng_done     (eng_done),
    .out_idx      (out_idx),
    .score_in     (score_in),
    .busy         (busy),
    .result_valid (result_valid),
    .class_id     (class_id),
    .max_score    (max_score),
    .margin       (margin)
  );

  // Engine output mux model: score returned combinationally for out_idx.
  assign score_in = scores[out_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_vec();
    for (int i = 0; i < 16; i++) scores[i] = 2'sd0;
    for (int i = 0; i < 10; i++) scores[i] = 2'(vec[i]);
  endtask

  // Fresh rising edge on eng_done, then 1 start cycle + 10 scan cycles.
  task automatic run_scan();
    eng_done = 1'b0;
    tick();
    eng_done = 1'b1;
    repeat (11) tick();
  endtask

  initial begin
    vecs     = 0;
    errs     = 0;
    rst      = 1'b0;
    clear    = 1'b0;
    eng_done = 1'b0;
    vec      = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_vec();

    // Reset state
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_class", class_id, 0);
    chk("rst_max", max_score, 0);
    chk("rst_margin", margin, 0);
    rst = 1'b1;
    tick();

    // Basic scan with step-by-step out_idx and latency
    vec = '{-2, -2, 1, 0, -1, -2, -2, -2, -2, -2};
    load_vec();
    eng_done = 1'b1;
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_valid_low", result_valid, 0);
    chk("t1_idx0", out_idx, 0);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("t1_idx_step", out_idx, i);
    end
    chk("t1_valid_before", result_valid, 0);
    tick();
    chk("t1_valid", result_valid, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_out_idx_hold", out_idx, 0);
    chk("t1_class", class_id, 2);
    chk("t1_max", max_score, 1);
    chk("t1_margin", margin, 1);
    // eng_done still held high: exactly one scan
    repeat (3) tick();
    chk("t1_held_valid", result_valid, 1);
    chk("t1_held_busy", busy, 0);
    chk("t1_held_class", class_id, 2);

    // Tie: lower index wins, margin 0
    vec = '{-1, -1, -1, 1, -1, -1, -1, 1, -1, -1};
    load_vec();
    run_scan();
    chk("tie_valid", result_valid, 1);
    chk("tie_class", class_id, 3);
    chk("tie_max", max_score, 1);
    chk("tie_margin", margin, 0);

    // All scores at the most-negative value
    vec = '{-2, -2, -2, -2, -2, -2, -2, -2, -2, -2};
    load_vec();
    run_scan();
    chk("neg_valid", result_valid, 1);
    chk("neg_class", class_id, 0);
    chk("neg_max", max_score, -2);
    chk("neg_margin", margin, 0);

    // clear at out_idx 5
    eng_done = 1'b0;
    tick();
    eng_done = 1'b1;
    tick();
    repeat (5) tick();
    chk("clr_at5", out_idx, 5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_out_idx", out_idx, 0);
    chk("clr_valid", result_valid, 0);
    vec = '{-1, 0, -2, -1, 1, -2, 0, -1, -1, 0};
    load_vec();
    run_scan();
    chk("clr_rescan_valid", result_valid, 1);
    chk("clr_rescan_class", class_id, 4);
    chk("clr_rescan_max", max_score, 1);
    chk("clr_rescan_margin", margin, 1);

    // eng_done falls at out_idx 4
    eng_done = 1'b0;
    tick();
    eng_done = 1'b1;
    tick();
    repeat (4) tick();
    chk("fall_at4", out_idx, 4);
    eng_done = 1'b0;
    tick();
    chk("fall_busy", busy, 0);
    chk("fall_valid", result_valid, 0);
    chk("fall_out_idx", out_idx, 0);

    // Same sequence, asynchronous reset mid-cycle
    eng_done = 1'b1;
    tick();
    repeat (4) tick();
    chk("arst_at4", out_idx, 4);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_out_idx", out_idx, 0);
    chk("arst_class", class_id, 0);
    chk("arst_max", max_score, 0);
    chk("arst_margin", margin, 0);
    eng_done = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Back-to-back runs
    vec = '{-2, -2, 1, 0, -1, -2, -2, -2, -2, -2};
    load_vec();
    run_scan();
    chk("b2b_first_class", class_id, 2);
    chk("b2b_first_valid", result_valid, 1);
    eng_done = 1'b0;
    vec = '{0, -1, -2, 0, -1, 0, -2, -1, 0, 1};
    load_vec();
    tick();
    chk("b2b_fall_hold", result_valid, 1);
    eng_done = 1'b1;
    tick();
    chk("b2b_rescan_valid", result_valid, 0);
    chk("b2b_rescan_busy", busy, 1);
    repeat (10) tick();
    chk("b2b_valid", result_valid, 1);
    chk("b2b_class", class_id, 9);
    chk("b2b_max", max_score, 1);
    chk("b2b_margin", margin, 1);

    // clear and start_pulse in the same cycle
    eng_done = 1'b0;
    tick();
    eng_done = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cs_valid", result_valid, 0);
    chk("cs_busy", busy, 0);
    chk("cs_out_idx", out_idx, 0);
    tick();
    chk("cs_no_scan", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
